// File: rtl/uart_rx_fifo.sv
// Receive-side FWFT FIFO behind the UART receiver: captures {error, data} on rx_ready pulses,
// reports fill level, almost_full and sticky overflow. Optional macro: UART_RX_FIFO_DROP_ERRORED_EN.

`ifndef UART_CONFIG_WIDTH_DATABITS
`define UART_CONFIG_WIDTH_DATABITS 8
`endif

module uart_rx_fifo #(
    parameter int DATA_WIDTH  = `UART_CONFIG_WIDTH_DATABITS,
    parameter int DEPTH       = 16,
    parameter int AFULL_LEVEL = DEPTH - 2
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [DATA_WIDTH-1:0]   rx_data,
    input  logic                    rx_ready,
    input  logic                    rx_error,
    input  logic                    flush,
    output logic [DATA_WIDTH-1:0]   rd_data,
    output logic                    rd_error,
    output logic                    rd_valid,
    input  logic                    rd_ack,
    output logic [$clog2(DEPTH):0]  count,
    output logic                    almost_full,
    output logic                    overflow,
    input  logic                    overflow_clear
);

    localparam int AW    = $clog2(DEPTH);
    localparam int PTR_W = AW + 1;

`ifdef UART_RX_FIFO_DROP_ERRORED_EN
    typedef logic [DATA_WIDTH-1:0] entry_t;
`else
    typedef struct packed {
        logic                  error;
        logic [DATA_WIDTH-1:0] data;
    } entry_t;
`endif

    entry_t             mem_q [DEPTH];
    entry_t             wr_entry;
    entry_t             head_entry;

    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic               overflow_q, overflow_d;

    logic [PTR_W-1:0]   fill;
    logic               full;
    logic               empty;
    logic               push_req;
    logic               push_en;
    logic               pop_en;
    logic               overflow_set;

    // Pointers carry one extra wrap bit, so the modulo difference spans 0..DEPTH.
    always_comb begin
        fill  = wr_ptr_q - rd_ptr_q;
        full  = (fill == PTR_W'(DEPTH));
        empty = (fill == '0);
    end

    always_comb begin
`ifdef UART_RX_FIFO_DROP_ERRORED_EN
        push_req = rx_ready && !rx_error;
`else
        push_req = rx_ready;
`endif
        pop_en       = !empty && rd_ack;
        // A pop in the same cycle frees the slot the push needs when full.
        push_en      = push_req && (!full || pop_en);
        overflow_set = push_req && full && !pop_en && !flush;
    end

    // NOTE: every signal driven here gets a default first, so no path leaves it unassigned (no latch).
    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        overflow_d = overflow_q;

        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
        end else begin
            if (push_en) wr_ptr_d = wr_ptr_q + 1'b1;
            if (pop_en)  rd_ptr_d = rd_ptr_q + 1'b1;
        end

        if (overflow_clear) overflow_d = 1'b0;
        if (overflow_set)   overflow_d = 1'b1;
    end

    // NOTE: state registers use non-blocking assignments so all flops update from pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            overflow_q <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            overflow_q <= overflow_d;
        end
    end

    always_comb begin
`ifdef UART_RX_FIFO_DROP_ERRORED_EN
        wr_entry = rx_data;
`else
        wr_entry       = '0;
        wr_entry.error = rx_error;
        wr_entry.data  = rx_data;
`endif
    end

    // NOTE: storage is deliberately left unreset; empty gating on the read side hides stale contents.
    always_ff @(posedge clk) begin
        if (push_en && !flush) begin
            mem_q[wr_ptr_q[AW-1:0]] <= wr_entry;
        end
    end

    always_comb begin
        head_entry = mem_q[rd_ptr_q[AW-1:0]];
        rd_valid   = !empty;
`ifdef UART_RX_FIFO_DROP_ERRORED_EN
        rd_data  = empty ? '0 : head_entry;
        rd_error = 1'b0;
`else
        rd_data  = empty ? '0 : head_entry.data;
        rd_error = !empty && head_entry.error;
`endif
        count       = fill;
        almost_full = (fill >= PTR_W'(AFULL_LEVEL));
        overflow    = overflow_q;
    end

endmodule

// File: doc/uart_rx_fifo.md
Name: uart_rx_fifo

Overview:
Receive-side buffer directly downstream of the UART receiver. Captures each received word on the receiver's one-cycle ready pulse, together with its parity-error flag. Holds the words in a circular FIFO and presents them to the consumer (echo logic / host) through a first-word-fall-through valid/ack interface. Reports fill level and a sticky overflow flag.

Parameters:
DATA_WIDTH, `UART_CONFIG_WIDTH_DATABITS, width of stored data word; matches receiver dataout width
DEPTH, 16, number of entries; power of two, >= 2
AFULL_LEVEL, DEPTH-2, count at or above which almost_full asserts; 1..DEPTH

Ports:
clk  input  1  system clock, all logic on posedge
rst_n  input  1  asynchronous active-low reset
rx_data  input  DATA_WIDTH  received word from receiver
rx_ready  input  1  one-cycle pulse; rx_data/rx_error valid this cycle
rx_error  input  1  parity error flag for rx_data
flush  input  1  synchronous clear of FIFO contents
rd_data  output  DATA_WIDTH  head-of-FIFO word
rd_error  output  1  error flag stored with head word
rd_valid  output  1  FIFO non-empty; rd_data/rd_error valid
rd_ack  input  1  pop head word when rd_valid high
count  output  $clog2(DEPTH)+1  number of stored entries, 0..DEPTH
almost_full  output  1  count >= AFULL_LEVEL
overflow  output  1  sticky: a word was dropped because FIFO full
overflow_clear  input  1  clears overflow

Behaviour:
- Reset (rst_n low, asynchronous): wr/rd pointers 0, count 0, rd_valid 0, almost_full 0, overflow 0. rd_data and rd_error read 0. Storage array is not reset.
- Storage: DEPTH entries of {error, data}. Pointers are $clog2(DEPTH)+1 bits with natural wrap. count = wr_ptr - rd_ptr (modulo). Full = count == DEPTH. Empty = count == 0.
- Push: rx_ready high at edge N and not full → entry written, wr_ptr+1. count, rd_valid and almost_full reflect it from edge N. Write-to-rd_valid latency is 1 clock.
- Pop: rd_valid && rd_ack at edge → rd_ptr+1. rd_ack is ignored while rd_valid low.
- FWFT: rd_valid = !empty. rd_data/rd_error = entry at rd_ptr while rd_valid, else 0.
- Simultaneous push+pop:
  - Not empty, not full: both occur, count unchanged.
  - Full: pop frees a slot, so the push is accepted; count stays DEPTH; no overflow.
  - Empty: push only.
- Overflow: rx_ready while full and no pop → word discarded, pointers unchanged, overflow set at that edge. overflow_clear clears it. If a set and a clear occur in the same cycle, the set wins.
- flush (synchronous, highest priority): pointers to 0, count 0. Any push/pop in that cycle is discarded. overflow is not affected.
- Back-to-back rx_ready pulses on consecutive cycles are each accepted; no minimum spacing is required.
- No state machine beyond the pointers. The design must sustain one push and one pop per clock indefinitely.

Optional Feature:
Macro: UART_RX_FIFO_DROP_ERRORED_EN
- Defined: rx_ready with rx_error=1 is discarded and never stored. It does not set overflow even when the FIFO is full. rd_error is constant 0; the stored entry width is DATA_WIDTH.
- Undefined: errored words are stored normally, with rd_error=1 presented alongside the word.

Test Plan:
- Reset then push 0x41, 0x42 (one pulse each, 3 cycles apart) → rd_valid high 1 cycle after first pulse; rd_data=0x41, count=2; rd_ack → rd_data=0x42, count=1; rd_ack → rd_valid=0, rd_data=0.
- Fill DEPTH=16 words 0x00..0x0F, then push 0xAA with no ack → count=16, almost_full=1, overflow=1; drain gives 0x00..0x0F in order; overflow_clear → overflow=0.
- Full FIFO, rx_ready=0x55 and rd_ack in the same cycle → no overflow, count stays 16; last entry drained is 0x55.
- Push 0x33 with rx_error=1 → macro undefined: rd_data=0x33, rd_error=1; macro defined: rd_valid stays 0, count=0.
- Push 5 words, assert flush together with rx_ready=0x77 → count=0, rd_valid=0, 0x77 not stored. Assert rst_n low mid-stream (asynchronously, between edges) → count=0 and rd_valid=0 immediately, without waiting for a clock edge.
